// File: rtl/dcpu16_fsmem_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcpu16_fsmem_if : DCPU16 FETCH/STORE bus bundle (master = core side)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface dcpu16_fsmem_if;
   logic        fs_stb;
   logic        fs_wre;
   logic [15:0] fs_adr;
   logic [15:0] fs_dto;
   logic [15:0] fs_dti;
   logic        fs_ack;

   modport master (output fs_stb, fs_wre, fs_adr, fs_dto, input fs_dti, fs_ack);
   modport slave  (input fs_stb, fs_wre, fs_adr, fs_dto, output fs_dti, fs_ack);
endinterface
`default_nettype wire

// File: rtl/dcpu16_fsmem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcpu16_fsmem : word-addressed RAM responder for the DCPU16 FS bus
// Revision: 1.0
// ---------------------------------------------------------------------------
module dcpu16_fsmem #(
   parameter int          AW   = 10,
   parameter logic [15:0] BASE = 16'h0000,
   parameter int          WAIT = 0
) (
   input  logic           clk,
   input  logic           rst,
   dcpu16_fsmem_if.slave  fs
);
   localparam logic [3:0] c_wait_ld = (WAIT > 15) ? 4'd15 : 4'(WAIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_latch;
   logic        w_act;
   logic [15:0] r_adr;
   logic        r_wre;
   logic [15:0] r_dto;
   logic [15:0] r_dti;
   logic        r_ack;
   logic        w_hit;
   logic [AW-1:0] w_idx;
   logic [15:0] r_mem [0:(1<<AW)-1];

   assign w_hit = (r_adr[15:AW] == BASE[15:AW]);
   assign w_idx = r_adr[AW-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_act       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (fs.fs_stb) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = c_wait_ld;
               w_state_nxt = (c_wait_ld == 4'd0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!fs.fs_stb) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  w_state_nxt = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            // Transfer is committed on the edge leaving ACK, together with the
            // registered ack, so a reset arriving in ACK still drops the write.
            w_act       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_ack   <= 1'b0;
         r_dti   <= 16'h0000;
         r_adr   <= 16'h0000;
         r_wre   <= 1'b0;
         r_dto   <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_act;
         if (w_latch) begin
            r_adr <= fs.fs_adr;
            r_wre <= fs.fs_wre;
            r_dto <= fs.fs_dto;
         end
         if (w_act && !r_wre) begin
            r_dti <= w_hit ? r_mem[w_idx] : 16'h0000;
         end
      end
   end

   // RAM array carries no reset so it maps onto block memory.
   always_ff @(posedge clk) begin
      if (rst && w_act && r_wre && w_hit) begin
         r_mem[w_idx] <= r_dto;
      end
   end

   assign fs.fs_dti = r_dti;
   assign fs.fs_ack = r_ack;
endmodule
`default_nettype wire

// File: tb/tb_dcpu16_fsmem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dcpu16_fsmem : three responders (WAIT 0/2/3) against a word-array model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dcpu16_fsmem;
   logic        clk;
   logic        rst;
   logic        stb [3];
   logic        wre [3];
   logic [15:0] adr [3];
   logic [15:0] dto [3];
   logic [15:0] dti [3];
   logic        ack [3];

   int tests = 0;
   int fails = 0;
   int wt [3] = '{0, 2, 3};

   // reference state: only the first 32 words of each RAM are ever read back
   logic [15:0] mm    [3][32];
   logic [15:0] dti_m [3];

   dcpu16_fsmem_if f0 ();
   dcpu16_fsmem_if f1 ();
   dcpu16_fsmem_if f2 ();

   assign f0.fs_stb = stb[0]; assign f0.fs_wre = wre[0];
   assign f0.fs_adr = adr[0]; assign f0.fs_dto = dto[0];
   assign f1.fs_stb = stb[1]; assign f1.fs_wre = wre[1];
   assign f1.fs_adr = adr[1]; assign f1.fs_dto = dto[1];
   assign f2.fs_stb = stb[2]; assign f2.fs_wre = wre[2];
   assign f2.fs_adr = adr[2]; assign f2.fs_dto = dto[2];
   assign dti[0] = f0.fs_dti; assign ack[0] = f0.fs_ack;
   assign dti[1] = f1.fs_dti; assign ack[1] = f1.fs_ack;
   assign dti[2] = f2.fs_dti; assign ack[2] = f2.fs_ack;

   dcpu16_fsmem #(.AW(10), .BASE(16'h0000), .WAIT(0)) u0 (.clk(clk), .rst(rst), .fs(f0));
   dcpu16_fsmem #(.AW(10), .BASE(16'h0000), .WAIT(2)) u1 (.clk(clk), .rst(rst), .fs(f1));
   dcpu16_fsmem #(.AW(10), .BASE(16'h0000), .WAIT(3)) u2 (.clk(clk), .rst(rst), .fs(f2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_hit(input logic [15:0] a);
      return a[15:10] == 6'd0;
   endfunction

   // One complete transfer; inputs are scrambled right after acceptance.
   task automatic xfer(input int k, input bit wr, input logic [15:0] a, input logic [15:0] d);
      int n;
      logic [15:0] exp_dti;
      @(negedge clk);
      stb[k] = 1'b1; wre[k] = wr; adr[k] = a; dto[k] = d;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (n == 1) begin
            adr[k] = a + 16'd1; dto[k] = ~d; wre[k] = !wr;
         end
      end while (!ack[k] && n < 40);
      stb[k] = 1'b0;
      if (wr) begin
         if (is_hit(a)) mm[k][a[4:0]] = d;
         exp_dti = dti_m[k];
      end else begin
         exp_dti  = is_hit(a) ? mm[k][a[4:0]] : 16'h0000;
         dti_m[k] = exp_dti;
      end
      check($sformatf("latency k%0d a%04h", k, a), n, wt[k] + 2);
      check($sformatf("dti k%0d %s a%04h", k, wr ? "st" : "ld", a), {16'd0, dti[k]}, {16'd0, exp_dti});
      @(posedge clk); #1;
      check($sformatf("ack_pulse k%0d", k), {31'd0, ack[k]}, 32'd0);
   endtask

   // Store whose strobe is withdrawn one cycle after acceptance.
   task automatic abort_store(input int k, input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      stb[k] = 1'b1; wre[k] = 1'b1; adr[k] = a; dto[k] = d;
      @(posedge clk); #1;
      stb[k] = 1'b0;
      for (int i = 0; i < wt[k] + 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("abort_noack k%0d", k), {31'd0, ack[k]}, 32'd0);
      end
   endtask

   initial begin
      int first [3];
      int n;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         stb[k] = 1'b1; wre[k] = 1'b0; adr[k] = 16'h8000; dto[k] = 16'h0000;
         dti_m[k] = 16'h0000; first[k] = -1;
      end

      // reset held with strobes asserted
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ack k%0d", k), {31'd0, ack[k]}, 32'd0);
            check($sformatf("rst_dti k%0d", k), {16'd0, dti[k]}, 32'd0);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1; n++;
         for (int k = 0; k < 3; k++) begin
            if (ack[k] && first[k] < 0) begin
               first[k] = n;
               stb[k] = 1'b0;
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         stb[k] = 1'b0;
         check($sformatf("first_ack k%0d", k), first[k], wt[k] + 2);
         check($sformatf("first_dti k%0d", k), {16'd0, dti[k]}, 32'd0);
      end

      // give every model word a known value
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 32; i++)
            xfer(k, 1'b1, 16'(i), 16'($urandom));

      // WAIT=0 store then fetch
      xfer(0, 1'b1, 16'h0005, 16'hBEEF);
      xfer(0, 1'b0, 16'h0005, 16'h0000);
      check("beef", {16'd0, dti[0]}, 32'h0000BEEF);

      // WAIT=3 fetch, address moved to 0x0006 during the wait
      xfer(2, 1'b1, 16'h0005, 16'h5555);
      xfer(2, 1'b1, 16'h0006, 16'h6666);
      xfer(2, 1'b0, 16'h0005, 16'h0000);

      // aborted store leaves old data
      abort_store(1, 16'h0007, 16'h1234);
      xfer(1, 1'b0, 16'h0007, 16'h0000);

      // out-of-window store and fetch
      xfer(0, 1'b1, 16'h0400, 16'hABCD);
      xfer(0, 1'b0, 16'h0400, 16'h0000);
      xfer(0, 1'b0, 16'h0000, 16'h0000);

      // reset during the wait of a store
      @(negedge clk);
      stb[2] = 1'b1; wre[2] = 1'b1; adr[2] = 16'h0009; dto[2] = 16'hDEAD;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("midrst_ack k%0d", k), {31'd0, ack[k]}, 32'd0);
         check($sformatf("midrst_dti k%0d", k), {16'd0, dti[k]}, 32'd0);
         dti_m[k] = 16'h0000;
      end
      rst = 1'b1; stb[2] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("midrst_noack", {31'd0, ack[2]}, 32'd0);
      end
      xfer(2, 1'b0, 16'h0009, 16'h0000);

      // randomized traffic
      for (int t = 0; t < 80; t++) begin
         int k;
         int r;
         logic [15:0] a;
         k = $urandom_range(0, 2);
         r = $urandom_range(0, 9);
         a = (r < 8) ? 16'($urandom_range(0, 31))
                     : {6'($urandom_range(1, 63)), 10'($urandom_range(0, 1023))};
         if (r == 0 && wt[k] >= 2)
            abort_store(k, a, 16'($urandom));
         else
            xfer(k, 1'($urandom_range(0, 1)), a, 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
